sd_kin_sequencer: RTL and testbench

- Programmable tuning-word scheduler that drives the kin input of sigma_delta_twopiece.
- Holds a small table of BITWIDTH-bit tuning words and steps through them in order. Each entry is held for a programmable dwell time.
- Moves between entries with a linear glide of 2^RAMP_SHIFT cycles, so the generator never sees a step discontinuity.
- Sits between the host/config logic and the sigma-delta generator; kin_out connects directly to kin.

---
 rtl/sd_seq_pkg.sv | 33 +++
 rtl/sd_kin_ramp.sv | 63 ++++++
 rtl/sd_kin_sequencer.sv | 163 ++++++++++++++++
 tb/tb_sd_kin_sequencer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_seq_pkg.sv
// Shared types and helpers for the kin sequencer: FSM state encoding, default sizes
// and the signed glide-step calculation.
package sd_seq_pkg;

  localparam int unsigned BitwidthDefault  = 40;
  localparam int unsigned DepthDefault     = 8;
  localparam int unsigned RampShiftDefault = 2;
  localparam int unsigned DwellWDefault    = 24;

  // Widest tuning word the step helper supports; callers zero-extend into it.
  localparam int unsigned StepMaxW = 64;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StRamp,
    StDwell,
    StFin
  } seq_state_e;

  // Signed difference is exact at StepMaxW+1 bits for any zero-extended narrower
  // word, so truncating the floor-shifted result to the caller's width gives the
  // modular per-cycle increment.
  function automatic logic [StepMaxW-1:0] calc_step(input logic [StepMaxW-1:0] target,
                                                    input logic [StepMaxW-1:0] cur,
                                                    input int unsigned shift);
    logic signed [StepMaxW:0] diff;
    diff = $signed({1'b0, target}) - $signed({1'b0, cur});
    diff = diff >>> shift;
    return diff[StepMaxW-1:0];
  endfunction

endpackage

// File: rtl/sd_kin_ramp.sv
// Glide engine: owns kin_out, the per-cycle step and the ramp counter. Walks from the
// current word towards a loaded target and snaps onto it on the last ramp cycle.
module sd_kin_ramp
  import sd_seq_pkg::*;
#(
  parameter int unsigned BITWIDTH   = BitwidthDefault,
  parameter int unsigned RAMP_SHIFT = RampShiftDefault
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load_i,
  input  logic [BITWIDTH-1:0] target_i,
  input  logic                advance_i,
  output logic [BITWIDTH-1:0] kin_o,
  output logic                ramp_last_o
);

  localparam int unsigned CntW = (RAMP_SHIFT == 0) ? 1 : RAMP_SHIFT;
  localparam logic [CntW-1:0] CntLast = CntW'((1 << RAMP_SHIFT) - 1);

  logic [BITWIDTH-1:0] kin_q, kin_d;
  logic [BITWIDTH-1:0] target_q, target_d;
  logic [BITWIDTH-1:0] step_q, step_d;
  logic [CntW-1:0]     cnt_q, cnt_d;

  always_comb begin
    kin_d    = kin_q;
    target_d = target_q;
    step_d   = step_q;
    cnt_d    = cnt_q;
    if (load_i) begin
      target_d = target_i;
      step_d   = BITWIDTH'(calc_step(StepMaxW'(target_i), StepMaxW'(kin_q), RAMP_SHIFT));
      cnt_d    = '0;
    end else if (advance_i) begin
      // Final cycle lands exactly on target, absorbing the floor rounding of step.
      if (cnt_q == CntLast) begin
        kin_d = target_q;
      end else begin
        kin_d = kin_q + step_q;
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      kin_q    <= '0;
      target_q <= '0;
      step_q   <= '0;
      cnt_q    <= '0;
    end else begin
      kin_q    <= kin_d;
      target_q <= target_d;
      step_q   <= step_d;
      cnt_q    <= cnt_d;
    end
  end

  assign kin_o       = kin_q;
  assign ramp_last_o = (cnt_q == CntLast);

endmodule

// File: rtl/sd_kin_sequencer.sv
// Tuning-word scheduler for the sigma-delta generator: steps through a small table,
// gliding between entries and dwelling on each for a programmable number of cycles.
module sd_kin_sequencer
  import sd_seq_pkg::*;
#(
  parameter int unsigned BITWIDTH   = BitwidthDefault,
  parameter int unsigned DEPTH      = DepthDefault,
  parameter int unsigned RAMP_SHIFT = RampShiftDefault,
  parameter int unsigned DWELL_W    = DwellWDefault
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cfg_we,
  input  logic [$clog2(DEPTH)-1:0]   cfg_addr,
  input  logic [BITWIDTH-1:0]        cfg_wdata,
  input  logic [$clog2(DEPTH):0]     cfg_len,
  input  logic [DWELL_W-1:0]         dwell_cycles,
  input  logic                       loop_en,
  input  logic                       start,
  input  logic                       stop,
  output logic [BITWIDTH-1:0]        kin_out,
  output logic                       kin_upd,
  output logic [$clog2(DEPTH)-1:0]   seg_idx,
  output logic                       busy,
  output logic                       done
);

  localparam int unsigned AddrW = $clog2(DEPTH);
  localparam int unsigned LenW  = AddrW + 1;

  seq_state_e state_q, state_d;

  logic [BITWIDTH-1:0] tbl_q [DEPTH];
  logic [BITWIDTH-1:0] tbl_d [DEPTH];

  logic [AddrW-1:0]   seg_idx_q, seg_idx_d;
  logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
  logic [LenW-1:0]    len_q, len_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic               loop_q, loop_d;
  logic               kin_upd_q, kin_upd_d;
  logic               done_q, done_d;

  logic               ramp_load, ramp_adv, ramp_last;
  logic               len_ok, last_seg, dwell_end;
  logic [DWELL_W-1:0] dwell_lim;

  assign len_ok    = (cfg_len != '0) && (cfg_len <= LenW'(DEPTH));
  assign last_seg  = (LenW'(seg_idx_q) + LenW'(1)) == len_q;
  // A programmed dwell of zero still holds the target for one cycle.
  assign dwell_lim = (dwell_q == '0) ? '0 : dwell_q - DWELL_W'(1);
  assign dwell_end = (dwell_cnt_q == dwell_lim);

  always_comb begin
    tbl_d = tbl_q;
    if (cfg_we) tbl_d[cfg_addr] = cfg_wdata;
  end

  always_comb begin
    state_d     = state_q;
    seg_idx_d   = seg_idx_q;
    dwell_cnt_d = dwell_cnt_q;
    len_d       = len_q;
    dwell_d     = dwell_q;
    loop_d      = loop_q;
    kin_upd_d   = 1'b0;
    done_d      = 1'b0;
    ramp_load   = 1'b0;
    ramp_adv    = 1'b0;

    // stop overrides everything, including a coincident start in IDLE.
    if (stop) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start && len_ok) begin
            len_d     = cfg_len;
            dwell_d   = dwell_cycles;
            loop_d    = loop_en;
            seg_idx_d = '0;
            state_d   = StLoad;
          end
        end
        StLoad: begin
          ramp_load = 1'b1;
          state_d   = StRamp;
        end
        StRamp: begin
          ramp_adv  = 1'b1;
          kin_upd_d = 1'b1;
          if (ramp_last) begin
            dwell_cnt_d = '0;
            state_d     = StDwell;
          end
        end
        StDwell: begin
          if (dwell_end) begin
            if (!last_seg) begin
              seg_idx_d = seg_idx_q + AddrW'(1);
              state_d   = StLoad;
            end else if (loop_q) begin
              seg_idx_d = '0;
              state_d   = StLoad;
            end else begin
              state_d = StFin;
            end
          end else begin
            dwell_cnt_d = dwell_cnt_q + DWELL_W'(1);
          end
        end
        StFin: begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      seg_idx_q   <= '0;
      dwell_cnt_q <= '0;
      len_q       <= '0;
      dwell_q     <= '0;
      loop_q      <= 1'b0;
      kin_upd_q   <= 1'b0;
      done_q      <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) tbl_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      seg_idx_q   <= seg_idx_d;
      dwell_cnt_q <= dwell_cnt_d;
      len_q       <= len_d;
      dwell_q     <= dwell_d;
      loop_q      <= loop_d;
      kin_upd_q   <= kin_upd_d;
      done_q      <= done_d;
      tbl_q       <= tbl_d;
    end
  end

  sd_kin_ramp #(
    .BITWIDTH  (BITWIDTH),
    .RAMP_SHIFT(RAMP_SHIFT)
  ) u_ramp (
    .clk        (clk),
    .reset      (reset),
    .load_i     (ramp_load),
    .target_i   (tbl_q[seg_idx_q]),
    .advance_i  (ramp_adv),
    .kin_o      (kin_out),
    .ramp_last_o(ramp_last)
  );

  assign kin_upd = kin_upd_q;
  assign seg_idx = seg_idx_q;
  assign busy    = (state_q != StIdle);
  assign done    = done_q;

endmodule

// File: tb/tb_sd_kin_sequencer.sv
// Directed bench for sd_kin_sequencer with hand-computed glide values.
module tb_sd_kin_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_we;
  logic [2:0]  cfg_addr;
  logic [39:0] cfg_wdata;
  logic [3:0]  cfg_len;
  logic [23:0] dwell_cycles;
  logic        loop_en;
  logic        start;
  logic        stop;
  logic [39:0] kin_out;
  logic        kin_upd;
  logic [2:0]  seg_idx;
  logic        busy;
  logic        done;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int upd_cnt = 0;

  sd_kin_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .cfg_we      (cfg_we),
    .cfg_addr    (cfg_addr),
    .cfg_wdata   (cfg_wdata),
    .cfg_len     (cfg_len),
    .dwell_cycles(dwell_cycles),
    .loop_en     (loop_en),
    .start       (start),
    .stop        (stop),
    .kin_out     (kin_out),
    .kin_upd     (kin_upd),
    .seg_idx     (seg_idx),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (kin_upd) upd_cnt++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input int a, input logic [39:0] d);
    cfg_we    = 1'b1;
    cfg_addr  = 3'(a);
    cfg_wdata = d;
    tick();
    cfg_we    = 1'b0;
  endtask

  task automatic go(input int len, input int dw, input bit lp);
    cfg_len      = 4'(len);
    dwell_cycles = 24'(dw);
    loop_en      = lp;
    start        = 1'b1;
    tick();
    start        = 1'b0;
  endtask

  initial begin
    logic [39:0] e1 [4];
    logic [39:0] e2 [4];
    logic [39:0] got [4];
    logic [2:0]  seq [5];
    logic [2:0]  prev;
    int          n, k, d0, u0;
    bit          mono;

    e1[0] = 40'h000550597A; e1[1] = 40'h000AA0B2F4;
    e1[2] = 40'h000FF10C6E; e1[3] = 40'h00154165E9;
    e2[0] = 40'h00137BF2C0; e2[1] = 40'h0011B67F97;
    e2[2] = 40'h000FF10C6E; e2[3] = 40'h000E2B9946;

    reset = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0; cfg_len = '0;
    dwell_cycles = '0; loop_en = 1'b0; start = 1'b0; stop = 1'b0;
    tick(); tick();
    chk("rst_kin", 64'(kin_out), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_done", 64'(done), 64'h0);
    chk("rst_upd", 64'(kin_upd), 64'h0);
    chk("rst_seg", 64'(seg_idx), 64'h0);
    reset = 1'b0;
    tick();

    // Invalid lengths are ignored.
    go(0, 5, 0);
    tick(); tick();
    chk("len0_busy", 64'(busy), 64'h0);
    chk("len0_kin", 64'(kin_out), 64'h0);
    go(9, 5, 0);
    tick();
    chk("len9_busy", 64'(busy), 64'h0);
    chk("len_bad_upd", 64'(upd_cnt), 64'h0);

    // Single-entry upward glide from 0.
    wr(0, 40'h00154165e9);
    wr(1, 40'h000e2b9946);
    d0 = done_cnt;
    go(1, 10, 0);
    chk("t1_busy", 64'(busy), 64'h1);
    tick();
    chk("t1_load_kin", 64'(kin_out), 64'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("t1_ramp%0d", i), 64'(kin_out), 64'(e1[i]));
      chk($sformatf("t1_upd%0d", i), 64'(kin_upd), 64'h1);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("t1_hold%0d", i), 64'({kin_out, kin_upd, busy, done}),
          64'({40'h00154165e9, 1'b0, 1'b1, 1'b0}));
    end
    tick();
    chk("t1_done", 64'(done), 64'h1);
    chk("t1_busy_off", 64'(busy), 64'h0);
    tick();
    chk("t1_done_once", 64'(done_cnt - d0), 64'h1);
    chk("t1_done_low", 64'(done), 64'h0);

    // Two entries: flat first segment, downward glide on the second.
    d0 = done_cnt;
    go(2, 2, 0);
    chk("t2_seg0", 64'(seg_idx), 64'h0);
    n = 0;
    while (seg_idx == 3'd0 && n < 40) begin tick(); n++; end
    chk("t2_seg1", 64'(seg_idx), 64'h1);
    chk("t2_seg0_kin", 64'(kin_out), 64'h00154165e9);
    k = 0;
    for (int i = 0; i < 12 && k < 4; i++) begin
      tick();
      if (kin_upd) begin got[k] = kin_out; k++; end
    end
    chk("t2_upd_n", 64'(k), 64'h4);
    mono = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t2_ramp%0d", i), 64'(got[i]), 64'(e2[i]));
      if (i > 0 && got[i] > got[i-1]) mono = 1'b0;
    end
    chk("t2_mono", 64'(mono), 64'h1);
    n = 0;
    while (!done && n < 20) begin tick(); n++; end
    chk("t2_done", 64'(done), 64'h1);
    chk("t2_final", 64'(kin_out), 64'h000e2b9946);

    // Looping over three entries, then stop mid-glide.
    wr(2, 40'h0000000100);
    d0 = done_cnt;
    go(3, 4, 1);
    prev = seg_idx;
    chk("t3_start_seg", 64'(prev), 64'h0);
    k = 0; n = 0;
    while (k < 5 && n < 200) begin
      tick(); n++;
      if (seg_idx != prev) begin seq[k] = seg_idx; prev = seg_idx; k++; end
    end
    chk("t3_trans_n", 64'(k), 64'h5);
    chk("t3_seq0", 64'(seq[0]), 64'h1);
    chk("t3_seq1", 64'(seq[1]), 64'h2);
    chk("t3_seq2", 64'(seq[2]), 64'h0);
    chk("t3_seq3", 64'(seq[3]), 64'h1);
    chk("t3_seq4", 64'(seq[4]), 64'h2);
    n = 0;
    while (seg_idx != 3'd1 && n < 60) begin tick(); n++; end
    n = 0;
    while (!kin_upd && n < 10) begin tick(); n++; end
    chk("t3_mid_kin", 64'(kin_out), 64'h00137BF2C0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("t3_stop_busy", 64'(busy), 64'h0);
    chk("t3_stop_kin", 64'(kin_out), 64'h00137BF2C0);
    chk("t3_stop_upd", 64'(kin_upd), 64'h0);
    tick(); tick();
    chk("t3_frozen", 64'({kin_out, busy, done}), 64'({40'h00137BF2C0, 1'b0, 1'b0}));
    chk("t3_nodone", 64'(done_cnt - d0), 64'h0);

    // Asynchronous reset in the middle of a dwell.
    go(1, 10, 0);
    n = 0;
    while (!kin_upd && n < 10) begin tick(); n++; end
    n = 0;
    while (kin_upd && n < 10) begin tick(); n++; end
    chk("t4_in_dwell", 64'({kin_out, busy}), 64'({40'h00154165e9, 1'b1}));
    #2;
    reset = 1'b1;
    #1;
    chk("t4_rst_kin", 64'(kin_out), 64'h0);
    chk("t4_rst_busy", 64'(busy), 64'h0);
    @(negedge clk);
    reset = 1'b0;
    tick();
    u0 = upd_cnt;
    d0 = done_cnt;
    go(1, 1, 0);
    n = 0;
    while (!done && n < 20) begin tick(); n++; end
    chk("t4_done", 64'(done), 64'h1);
    chk("t4_kin_zero", 64'(kin_out), 64'h0);
    chk("t4_upd_n", 64'(upd_cnt - u0), 64'h4);

    // stop+start together, then start pulses while busy.
    wr(0, 40'h0000001000);
    u0 = upd_cnt;
    cfg_len = 4'd1; dwell_cycles = 24'd3; loop_en = 1'b0;
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    tick(); tick();
    chk("t5_ss_busy", 64'(busy), 64'h0);
    chk("t5_ss_upd", 64'(upd_cnt - u0), 64'h0);
    d0 = done_cnt;
    go(1, 3, 0);
    n = 0;
    while (!done && n < 30) begin
      start = (n == 2 || n == 6);
      tick();
      start = 1'b0;
      n++;
    end
    chk("t5_latency", 64'(n), 64'h9);
    chk("t5_kin", 64'(kin_out), 64'h0000001000);
    tick(); tick();
    chk("t5_no_restart", 64'(busy), 64'h0);
    chk("t5_done_once", 64'(done_cnt - d0), 64'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
